// File: rtl/fp_pkg.sv
// Shared FP add/sub datapath definitions: field widths, exponent limit,
// rounding-mode encoding and the normalizer result record.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic [2:0]       grs;
    logic             underflow;
  } norm_out_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports W.
module fp_lzc #(
  parameter int W   = 27,
  parameter int LZW = 5
) (
  input  logic [W-1:0]   vec,
  output logic [LZW-1:0] lz
);

  // The highest set bit is visited last, so its count wins.
  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) lz = LZW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_norm_pipe.sv
// Two-stage normalizer between the mantissa adder and rounding, elastic handshake.
// Define FNORM_SUBNORMAL_EN to emit subnormals instead of flushing to zero.
module fadd_norm_pipe #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int LZC_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W+4:0] sum_mag,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             sign_in,
  input  logic             eff_sub,
  input  logic             nan_in,
  input  logic             inf1_in,
  input  logic             inf2_in,
  input  logic             sign1_in,
  input  logic             sign2_in,
  input  logic [2:0]       rm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_res,
  output logic [EXP_W-1:0] exp_norm,
  output logic [MAN_W-1:0] mantissa_norm,
  output logic [2:0]       grs,
  output logic             underflow,
  output logic             nan_o,
  output logic             inf1_o,
  output logic             inf2_o,
  output logic             sign1_o,
  output logic             sign2_o,
  output logic [2:0]       rm_o
);

  import fp_pkg::*;

  localparam int SUM_W = MAN_W + 5;

  logic             s1_adv, s2_adv;
  logic             vld_p1, vld_p2;
  logic [SUM_W-1:0] mag_p1;
  logic [EXP_W-1:0] exp_p1;
  logic             sign_p1, eff_sub_p1;
  logic [LZC_W-1:0] lz_p1;
  logic [7:0]       flags_p1, flags_p2;
  logic [2:0]       rm_p1;
  logic [LZC_W-1:0] lz_c;
  norm_out_t        res_c, res_p2;

  function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] e);
    logic [EXP_W:0] wide;
    wide = {1'b0, e} + 1'b1;
    return wide[EXP_W] ? EXP_MAX : wide[EXP_W-1:0];
  endfunction

  function automatic norm_out_t normalize(
    input logic [SUM_W-1:0] mag,
    input logic [EXP_W-1:0] e,
    input logic [LZC_W-1:0] lz,
    input logic             sgn,
    input logic             esub,
    input logic [2:0]       rm
  );
    norm_out_t        r;
    logic [MAN_W+3:0] sh;
`ifdef FNORM_SUBNORMAL_EN
    logic [EXP_W-1:0] sub_amt;
`endif
    r      = '0;
    r.sign = sgn;
    sh     = '0;
    if (mag == '0) begin
      r.sign = esub ? (rm == RDN) : sgn;
    end else if (mag[MAN_W+4]) begin
      r.man = mag[MAN_W+3:4];
      r.grs = {mag[3], mag[2], mag[1] | mag[0]};
      r.exp = sat_inc(e);
    end else if (EXP_W'(lz) < e) begin
      sh    = mag[MAN_W+3:0] << lz;
      r.man = sh[MAN_W+2:3];
      r.grs = sh[2:0];
      r.exp = e - EXP_W'(lz);
    end else begin
`ifdef FNORM_SUBNORMAL_EN
      // Denormalize only as far as the minimum exponent allows.
      sub_amt = (e == '0) ? '0 : e - 1'b1;
      sh      = mag[MAN_W+3:0] << sub_amt;
      r.man   = sh[MAN_W+2:3];
      r.grs   = sh[2:0];
`else
      r.underflow = 1'b1;
`endif
    end
    return r;
  endfunction

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  fp_lzc #(.W(MAN_W + 4), .LZW(LZC_W)) u_lzc (
    .vec (sum_mag[MAN_W+3:0]),
    .lz  (lz_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture raw sum, exponent, flags and leading-zero count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_p1     <= '0;
      exp_p1     <= '0;
      sign_p1    <= 1'b0;
      eff_sub_p1 <= 1'b0;
      lz_p1      <= '0;
      flags_p1   <= '0;
      rm_p1      <= '0;
    end else if (s1_adv && in_valid) begin
      mag_p1     <= sum_mag;
      exp_p1     <= exp_in;
      sign_p1    <= sign_in;
      eff_sub_p1 <= eff_sub;
      lz_p1      <= lz_c;
      flags_p1   <= {nan_in, inf1_in, inf2_in, sign1_in, sign2_in, rm_in};
      rm_p1      <= rm_in;
    end
  end

  assign res_c = normalize(mag_p1, exp_p1, lz_p1, sign_p1, eff_sub_p1, rm_p1);

  // Stage 2: normalized result registers feeding rounding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_p2   <= '0;
      flags_p2 <= '0;
    end else if (s2_adv && vld_p1) begin
      res_p2   <= res_c;
      flags_p2 <= flags_p1;
    end
  end

  assign out_valid     = vld_p2;
  assign sign_res      = res_p2.sign;
  assign exp_norm      = res_p2.exp;
  assign mantissa_norm = res_p2.man;
  assign grs           = res_p2.grs;
  assign underflow     = res_p2.underflow;
  assign {nan_o, inf1_o, inf2_o, sign1_o, sign2_o, rm_o} = flags_p2;

endmodule

// File: tb/tb_fadd_norm_pipe.sv
// Randomized scoreboard bench for fadd_norm_pipe with directed corner cases.
module tb_fadd_norm_pipe;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [27:0] sum_mag;
  logic [7:0]  exp_in, exp_norm;
  logic        sign_in, eff_sub, nan_in, inf1_in, inf2_in, sign1_in, sign2_in;
  logic [2:0]  rm_in, rm_o, grs;
  logic        sign_res, underflow, nan_o, inf1_o, inf2_o, sign1_o, sign2_o;
  logic [22:0] mantissa_norm;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic [2:0]  grs;
    logic        uf;
    logic [7:0]  fl;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t dut_val;
  res_t held_val;
  logic held = 1'b0;

  always #5 clk = ~clk;

  fadd_norm_pipe dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_mag(sum_mag), .exp_in(exp_in), .sign_in(sign_in), .eff_sub(eff_sub),
    .nan_in(nan_in), .inf1_in(inf1_in), .inf2_in(inf2_in),
    .sign1_in(sign1_in), .sign2_in(sign2_in), .rm_in(rm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_res(sign_res), .exp_norm(exp_norm), .mantissa_norm(mantissa_norm),
    .grs(grs), .underflow(underflow),
    .nan_o(nan_o), .inf1_o(inf1_o), .inf2_o(inf2_o),
    .sign1_o(sign1_o), .sign2_o(sign2_o), .rm_o(rm_o)
  );

  assign dut_val = '{sign_res, exp_norm, mantissa_norm, grs, underflow,
                     {nan_o, inf1_o, inf2_o, sign1_o, sign2_o, rm_o}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: place the leading one at the hidden position by plain arithmetic.
  function automatic res_t model(input logic [27:0] m, input logic [7:0] e,
                                 input logic sg, input logic es,
                                 input logic [2:0] rm, input logic [7:0] fl);
    res_t    r;
    int      p, lzn, sh;
    longint  v;
    r = '0;
    r.fl = fl;
    r.sign = sg;
    if (m == 0) begin
      r.sign = es ? (rm == 3'd2) : sg;
      return r;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    v = longint'(m);
    if (p == 27) begin
      r.exp = (int'(e) + 1 > 255) ? 8'd255 : 8'(int'(e) + 1);
      r.man = 23'((v / 16) % (1 << 23));
      r.grs = {m[3], m[2], (v % 4) != 0};
      return r;
    end
    lzn = 26 - p;
    if (lzn < int'(e)) begin
      v = v * (longint'(1) << lzn);
      r.exp = 8'(int'(e) - lzn);
    end else begin
`ifdef FNORM_SUBNORMAL_EN
      sh = (e == 0) ? 0 : int'(e) - 1;
      v = v * (longint'(1) << sh);
`else
      sh = 0;
      r.uf = 1'b1;
      return r;
`endif
    end
    r.man = 23'((v / 8) % (1 << 23));
    r.grs = 3'(v % 8);
    return r;
  endfunction

  // Scoreboard and stall-stability checker.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      held <= 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_stable", 64'(dut_val), 64'(held_val));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else chk("scoreboard", 64'(dut_val), 64'(q.pop_front()));
      end
      held <= out_valid && !out_ready && !flush;
      held_val <= dut_val;
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(sum_mag, exp_in, sign_in, eff_sub, rm_in,
                          {nan_in, inf1_in, inf2_in, sign1_in, sign2_in, rm_in}));
    end
  end

  task automatic drive(input logic [27:0] m, input logic [7:0] e, input logic es,
                       input logic [2:0] rm, input logic sg);
    in_valid = 1'b1; sum_mag = m; exp_in = e; eff_sub = es; rm_in = rm; sign_in = sg;
    {nan_in, inf1_in, inf2_in, sign1_in, sign2_in} = 5'($urandom);
  endtask

  task automatic one(input string name, input logic [27:0] m, input logic [7:0] e,
                     input logic es, input logic [2:0] rm, input logic sg,
                     input logic [7:0] x_exp, input logic [22:0] x_man,
                     input logic [2:0] x_grs, input logic x_uf, input logic x_sign);
    @(posedge clk); #1;
    drive(m, e, es, rm, sg);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_res"}, {exp_norm, mantissa_norm, grs, underflow, sign_res},
        {x_exp, x_man, x_grs, x_uf, x_sign});
  endtask

  initial begin
    res_t pm;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(28'h0, 8'h0, 1'b0, 3'd0, 1'b0);
    in_valid = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_data", 64'(dut_val), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Pin the reference model against hand-computed values.
    pm = model({2'b11, 23'h0, 3'b011}, 8'd127, 1'b0, 1'b0, 3'd0, 8'h0);
    chk("model_carry", {pm.exp, pm.man, pm.grs}, {8'd128, 23'h400000, 3'b001});
    pm = model(28'h1000000, 8'd127, 1'b0, 1'b0, 3'd0, 8'h0);
    chk("model_cancel", {pm.exp, pm.man, pm.grs}, {8'd125, 23'h0, 3'b000});
    pm = model(28'h0, 8'd50, 1'b0, 1'b1, 3'd2, 8'h0);
    chk("model_zero_rdn", 64'(pm.sign), 64'd1);

    one("carry", {2'b11, 23'h0, 3'b011}, 8'd127, 1'b0, 3'd0, 1'b1,
        8'd128, 23'h400000, 3'b001, 1'b0, 1'b1);
    one("cancel", 28'h1000000, 8'd127, 1'b1, 3'd0, 1'b0,
        8'd125, 23'h0, 3'b000, 1'b0, 1'b0);
    one("zero_rdn", 28'h0, 8'd90, 1'b1, 3'd2, 1'b0, 8'd0, 23'h0, 3'b000, 1'b0, 1'b1);
    one("zero_rne", 28'h0, 8'd90, 1'b1, 3'd0, 1'b1, 8'd0, 23'h0, 3'b000, 1'b0, 1'b0);
    one("ovf_254", {2'b11, 26'h0}, 8'd254, 1'b0, 3'd0, 1'b0,
        8'd255, 23'h400000, 3'b000, 1'b0, 1'b0);
    one("ovf_255", {2'b10, 26'h0}, 8'd255, 1'b0, 3'd0, 1'b0,
        8'd255, 23'h0, 3'b000, 1'b0, 1'b0);
`ifdef FNORM_SUBNORMAL_EN
    one("underflow", 28'h0011235, 8'd5, 1'b0, 3'd0, 1'b0,
        8'd0, 23'h2246A, 3'b000, 1'b0, 1'b0);
`else
    one("underflow", 28'h0011235, 8'd5, 1'b0, 3'd0, 1'b1,
        8'd0, 23'h0, 3'b000, 1'b1, 1'b1);
`endif

    // Four-entry stream with a two-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 4) drive(28'h0800000 + 28'(i * 28'h11111), 8'(100 + i), 1'b0, 3'(i), 1'b0);
      else in_valid = 1'b0;
      out_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
    end

    // Flush with two entries in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(28'h0400000, 8'd60, 1'b0, 3'd1, 1'b0);
    end
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_s1_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with entries in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(28'h0200000, 8'd70, 1'b0, 3'd3, 1'b1);
    end
    #2; in_valid = 1'b0; reset_n = 1'b0;
    #10; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_drain", 64'(out_valid), 64'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [27:0] m;
      logic [7:0]  e;
      @(posedge clk); #1;
      m = 28'($urandom) >> $urandom_range(0, 28);
      if ($urandom_range(0, 15) == 0) m = 28'h0;
      e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      drive(m, e, 1'($urandom), 3'($urandom_range(0, 4)), 1'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
